// File: rtl/seq_detector_param_if.sv
// Serial detector bus: stimulus from the bit-stream source, match and status back.
//   master: drives enable, i, overlap, load_pattern, pattern_in, count_clear;
//           observes o, match_r, match_count, count_ovf.
//   slave : the detector side, with the opposite directions.
interface seq_detector_param_if #(
  parameter int PAT_WIDTH = 4,
  parameter int CNT_WIDTH = 8
) ();
  logic                 enable;
  logic                 i;
  logic                 overlap;
  logic                 load_pattern;
  logic [PAT_WIDTH-1:0] pattern_in;
  logic                 count_clear;
  logic                 o;
  logic                 match_r;
  logic [CNT_WIDTH-1:0] match_count;
  logic                 count_ovf;

  modport master (
    output enable, i, overlap, load_pattern, pattern_in, count_clear,
    input  o, match_r, match_count, count_ovf
  );

  modport slave (
    input  enable, i, overlap, load_pattern, pattern_in, count_clear,
    output o, match_r, match_count, count_ovf
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with a run-time loadable pattern,
// selectable overlapping detection and a saturating match counter.
//   clk   : system clock, rising edge
//   n_rst : synchronous active-low reset
//   bus   : seq_detector_param_if.slave
//           in : enable, i, overlap, load_pattern, pattern_in, count_clear
//           out: o (combinational Mealy match), match_r (o one cycle later),
//                match_count (saturating), count_ovf (sticky overflow)
module seq_detector_param #(
  parameter int                   PAT_WIDTH       = 4,
  parameter logic [PAT_WIDTH-1:0] DEFAULT_PATTERN = 4'b1101,
  parameter int                   CNT_WIDTH       = 8
) (
  input logic                 clk,
  input logic                 n_rst,
  seq_detector_param_if.slave bus
);

  localparam int             FW        = $clog2(PAT_WIDTH);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_WIDTH - 1);

  logic [PAT_WIDTH-2:0] hist, hist_next;
  logic [FW-1:0]        fill, fill_next;
  logic [PAT_WIDTH-1:0] pattern, pattern_next;
  logic [PAT_WIDTH-1:0] window;
  logic [CNT_WIDTH-1:0] count, count_next;
  logic                 ovf, ovf_next;
  logic                 match;
  logic                 match_reg;

  // History plus the live bit; the oldest bit lines up with pattern MSB.
  assign window = {hist, bus.i};

  // Gating with n_rst keeps o quiet while reset is held, even though the
  // registers only clear on the next edge.
  assign match = n_rst & bus.enable & ~bus.load_pattern &
                 (fill == FILL_FULL) & (window == pattern);

  assign bus.o           = match;
  assign bus.match_r     = match_reg;
  assign bus.match_count = count;
  assign bus.count_ovf   = ovf;

  always_comb begin
    hist_next    = hist;
    fill_next    = fill;
    pattern_next = pattern;
    count_next   = count;
    ovf_next     = ovf;

    if (bus.load_pattern) begin
      pattern_next = bus.pattern_in;
      hist_next    = '0;
      fill_next    = '0;
    end else if (bus.enable) begin
      if (match && !bus.overlap) begin
        // Non-overlapping: the next match must be built from fresh bits.
        hist_next = '0;
        fill_next = '0;
      end else begin
        // Dropping the window MSB also works when the history is one bit wide.
        hist_next = window[PAT_WIDTH-2:0];
        fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
      end
    end

    // A clear swallows a coincident match; otherwise saturate and flag.
    if (bus.count_clear) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (match) begin
      if (&count) begin
        ovf_next = 1'b1;
      end else begin
        count_next = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hist      <= '0;
      fill      <= '0;
      pattern   <= DEFAULT_PATTERN;
      count     <= '0;
      ovf       <= 1'b0;
      match_reg <= 1'b0;
    end else begin
      hist      <= hist_next;
      fill      <= fill_next;
      pattern   <= pattern_next;
      count     <= count_next;
      ovf       <= ovf_next;
      match_reg <= match;
    end
  end

endmodule
